// File: rtl/interp_frame_ctrl.sv
// Frame sequencer: fills the interpolation RAM with one frame, then drains it
// as a 2x linearly interpolated stream (sample, midpoint, sample, ...).
module interp_frame_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAME_LEN  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  frame_done,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  typedef enum logic [1:0] {FILL, PRIME1, PRIME2, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_LEN - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  phase_q, phase_d;
  logic                  b_pend_q, b_pend_d;
  logic                  s_ready_q, s_ready_d;
  logic                  in_xfer;
  logic                  out_xfer;
  logic [DATA_WIDTH:0]   sum;

  function automatic logic [ADDR_WIDTH-1:0] clamp(input logic [ADDR_WIDTH:0] k);
    logic [ADDR_WIDTH-1:0] r;
    if (k > {1'b0, LAST}) r = LAST;
    else                  r = k[ADDR_WIDTH-1:0];
    return r;
  endfunction

  // s_ready is a flop rather than a decode of state so it reads 0 during reset
  assign s_ready     = s_ready_q;
  assign in_xfer     = s_valid & s_ready_q;
  assign ram_wr_en   = in_xfer;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_wr_data = in_xfer ? s_data : '0;
  assign ram_rd_addr = rd_addr_d;

  assign m_valid    = (state_q == DRAIN);
  assign out_xfer   = m_valid & m_ready;
  assign m_last     = m_valid & phase_q & (n_q == LAST);
  assign frame_done = out_xfer & m_last;
  assign sum        = {a_q[DATA_WIDTH-1], a_q} + {b_q[DATA_WIDTH-1], b_q};
  assign m_data     = phase_q ? sum[DATA_WIDTH:1] : a_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    n_d       = n_q;
    rd_addr_d = rd_addr_q;
    a_d       = a_q;
    b_d       = b_q;
    phase_d   = phase_q;
    b_pend_d  = b_pend_q;
    case (state_q)
      FILL: begin
        if (in_xfer) begin
          if (wr_ptr_q == LAST) begin
            wr_ptr_d = '0;
            state_d  = PRIME1;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      PRIME1: begin
        rd_addr_d = '0;
        state_d   = PRIME2;
      end
      PRIME2: begin
        a_d       = ram_rd_data;
        rd_addr_d = clamp((ADDR_WIDTH+1)'(1));
        n_d       = '0;
        phase_d   = 1'b0;
        b_pend_d  = 1'b1;
        state_d   = DRAIN;
      end
      DRAIN: begin
        if (b_pend_q) begin
          b_d      = ram_rd_data;
          b_pend_d = 1'b0;
        end
        if (out_xfer) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            rd_addr_d = clamp({1'b0, n_q} + (ADDR_WIDTH+1)'(2));
            phase_d   = 1'b0;
            if (m_last) begin
              n_d      = '0;
              b_pend_d = 1'b0;
              state_d  = FILL;
            end else begin
              a_d      = b_q;
              n_d      = n_q + 1'b1;
              b_pend_d = 1'b1;
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
    s_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      wr_ptr_q  <= '0;
      n_q       <= '0;
      rd_addr_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      phase_q   <= 1'b0;
      b_pend_q  <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      n_q       <= n_d;
      rd_addr_q <= rd_addr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      phase_q   <= phase_d;
      b_pend_q  <= b_pend_d;
      s_ready_q <= s_ready_d;
    end
  end

endmodule
